onehot_encoder_pipe: RTL

ONEHOT_ENCODER_PIPE -- requirements
Module: onehot_encoder_pipe

---
 rtl/onehot_encoder_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/onehot_encoder_pipe.sv
// Two-stage valid/ready pipeline that encodes a 16-bit one-hot word to a
// 4-bit index, flags zero/multi-hot words and counts them (saturating).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable          gates acceptance of new words; pipeline still drains
//   in_valid/ready  input handshake, in_data 16-bit word
//   out_valid/ready output handshake, out_index/out_zero/out_multi result
//   err_clr         synchronous clear of err_count
//   err_count       saturating count of malformed (zero or multi-hot) words
module onehot_encoder_pipe #(
    parameter bit          PRIORITY_HIGH = 1'b0,
    parameter int unsigned ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_index,
    output logic                 out_zero,
    output logic                 out_multi,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

    logic                 r_s1_valid;
    logic [15:0]          r_s1_data;
    logic                 r_out_valid;
    logic [3:0]           r_out_index;
    logic                 r_out_zero;
    logic                 r_out_multi;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic                 w_s2_load;
    logic                 w_in_acc;
    logic [3:0]           w_idx;
    logic                 w_zero;
    logic                 w_multi;
    logic                 w_bad;

    // Stage 2 can take the stage-1 word when it is empty or draining now.
    assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready  = !rst && enable && (!r_s1_valid || w_s2_load);
    assign w_in_acc  = in_valid && in_ready;

    // Scan order decides which bit wins: the last match in the loop sticks.
    always_comb begin
        w_idx = 4'd0;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < 16; i++) begin
                if (r_s1_data[i]) w_idx = 4'(i);
            end
        end else begin
            for (int i = 15; i >= 0; i--) begin
                if (r_s1_data[i]) w_idx = 4'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_zero  = (r_s1_data == 16'h0000);
    assign w_multi = ((r_s1_data & (r_s1_data - 16'd1)) != 16'h0000);
    assign w_bad   = w_s2_load && (w_zero || w_multi);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= 16'h0000;
        end else if (w_in_acc) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= in_data;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_index <= 4'd0;
            r_out_zero  <= 1'b0;
            r_out_multi <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_out_index <= w_idx;
            r_out_zero  <= w_zero;
            r_out_multi <= w_multi;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // A clear coinciding with a malformed load leaves that one word counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= w_bad ? ERR_ONE : '0;
        end else if (w_bad && (r_err_count != ERR_MAX)) begin
            r_err_count <= r_err_count + ERR_ONE;
        end
    end

    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign out_zero  = r_out_zero;
    assign out_multi = r_out_multi;
    assign err_count = r_err_count;

endmodule
